// File: rtl/hex_ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hex_ser_pkg
//  Purpose  : Shared types and constants for the hex word serializer: the
//             controller state encoding, the ASCII code points it emits and
//             the default word width in hex digits.
//  Config   : HEX_SERIAL_CRLF_EN adds the SEP state, which appends CR/LF
//             after each word.
//  Revision : 1.0 - initial release
// ============================================================================
package hex_ser_pkg;

  // Default number of hex digits rendered per input word.
  localparam int c_nibbles_default = 8;

  // ASCII code points used by the serializer.
  localparam logic [7:0] c_zero    = 8'h30;
  localparam logic [7:0] c_upper_a = 8'h41;
  localparam logic [7:0] c_lower_a = 8'h61;
  localparam logic [7:0] c_cr      = 8'h0D;
  localparam logic [7:0] c_lf      = 8'h0A;

  // Controller states. SEP is only part of the encoding when the line
  // terminator feature is built in.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef HEX_SERIAL_CRLF_EN
    ST_SEP  = 2'd2,
`endif
    ST_EMIT = 2'd1
  } hex_ser_state_e;

endpackage : hex_ser_pkg
`default_nettype wire

// File: rtl/nibble_to_ascii.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_to_ascii
//  Purpose  : Purely combinational map from one 4-bit value to its ASCII hex
//             digit: 0..9 -> '0'..'9', 10..15 -> 'A'..'F' or 'a'..'f'.
//  Params   : UPPERCASE - nonzero selects 'A'..'F', zero selects 'a'..'f'
//  Ports    : nibble (in, 4)  value to render
//             ascii  (out, 8) ASCII character code
//  Revision : 1.0 - initial release
// ============================================================================
module nibble_to_ascii
  import hex_ser_pkg::*;
#(
  parameter int UPPERCASE = 1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Base code for the letter digits; 10 is subtracted below so that
  // nibble 10 lands exactly on 'A'/'a'.
  localparam logic [7:0] c_alpha_base = (UPPERCASE != 0) ? c_upper_a : c_lower_a;

  logic [7:0] w_nibble_ext;

  assign w_nibble_ext = {4'h0, nibble};

  always_comb begin
    ascii = c_zero + w_nibble_ext;
    if (nibble > 4'd9) begin
      ascii = c_alpha_base + w_nibble_ext - 8'd10;
    end
  end

endmodule : nibble_to_ascii
`default_nettype wire

// File: rtl/hex_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : hex_word_serializer
//  Purpose  : Accepts a binary word over a valid/ready handshake and emits it
//             as a stream of ASCII hex digits, most significant digit first,
//             over a second valid/ready handshake. One character per cycle at
//             peak; one idle cycle between words.
//  Params   : NIBBLES   - hex digits per input word (1..16)
//             UPPERCASE - 1 renders 'A'..'F', 0 renders 'a'..'f'
//  Config   : HEX_SERIAL_CRLF_EN - when defined, each word is followed by
//             CR (0x0D) and LF (0x0A), each under the output handshake.
//  Ports    : clk       (in)            rising-edge clock
//             rst_n     (in)            synchronous active-low reset
//             in_valid  (in)            upstream word available
//             in_ready  (out)           word can be accepted (IDLE only)
//             in_word   (in, 4*NIBBLES) word to render
//             out_valid (out)           out_char holds a character
//             out_ready (in)            downstream consumes out_char
//             out_char  (out, 8)        ASCII character (registered)
//             busy      (out)           controller not in IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module hex_word_serializer
  import hex_ser_pkg::*;
#(
  parameter int NIBBLES   = c_nibbles_default,
  parameter int UPPERCASE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_char,
  output logic                 busy
);

  localparam int c_word_w = 4 * NIBBLES;
  // A single-digit word still needs a 1-bit index register.
  localparam int c_idx_w  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NIBBLES - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

  hex_ser_state_e       r_state;
  logic [c_word_w-1:0]  r_word;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_out_valid;
  logic [7:0]           r_out_char;

  logic                 w_xfer;
  logic [c_idx_w-1:0]   w_next_idx;
  logic [3:0]           w_sel_nibble;
  logic [7:0]           w_ascii;

  assign w_xfer     = r_out_valid && out_ready;
  assign w_next_idx = r_idx - c_idx_one;

  // The mapper is shared between the accept path and the advance path.
  // In IDLE the first character comes straight from in_word so it can be
  // registered on the accept edge; afterwards the next digit is picked from
  // the latched copy. w_next_idx is only meaningful while r_idx > 0.
  always_comb begin
    w_sel_nibble = in_word[c_word_w-1 -: 4];
    if (r_state != ST_IDLE) begin
      w_sel_nibble = 4'h0;
      for (int i = 0; i < NIBBLES; i++) begin
        if (w_next_idx == c_idx_w'(i)) begin
          w_sel_nibble = r_word[i*4 +: 4];
        end
      end
    end
  end

  nibble_to_ascii #(
    .UPPERCASE (UPPERCASE)
  ) u_nibble_to_ascii (
    .nibble (w_sel_nibble),
    .ascii  (w_ascii)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_word      <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_char  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_word      <= in_word;
            r_idx       <= c_last_idx;
            r_out_char  <= w_ascii;
            r_out_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (w_xfer) begin
            if (r_idx != '0) begin
              r_idx      <= w_next_idx;
              r_out_char <= w_ascii;
            end else begin
`ifdef HEX_SERIAL_CRLF_EN
              r_state    <= ST_SEP;
              r_out_char <= c_cr;
`else
              r_state     <= ST_IDLE;
              r_out_valid <= 1'b0;
`endif
            end
          end
        end

`ifdef HEX_SERIAL_CRLF_EN
        // CR is always presented first, so the current character tells
        // which half of the terminator is pending.
        ST_SEP: begin
          if (w_xfer) begin
            if (r_out_char == c_cr) begin
              r_out_char <= c_lf;
            end else begin
              r_state     <= ST_IDLE;
              r_out_valid <= 1'b0;
            end
          end
        end
`endif

        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = r_out_valid;
  assign out_char  = r_out_char;

endmodule : hex_word_serializer
`default_nettype wire

// File: tb/tb_hex_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_word_serializer
//  Purpose  : Directed self-checking bench for hex_word_serializer. Two
//             instances share clock and reset: one rendering uppercase and
//             one rendering lowercase. Build with HEX_SERIAL_CRLF_EN to
//             exercise the CR/LF terminator.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hex_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_busy;
  logic [31:0] u_in_word;
  logic [7:0]  u_out_char;

  logic        l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_busy;
  logic [31:0] l_in_word;
  logic [7:0]  l_out_char;

  int errors = 0;
  int checks = 0;

  hex_word_serializer #(.NIBBLES(8), .UPPERCASE(1)) dut_upper (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (u_in_valid),
    .in_ready  (u_in_ready),
    .in_word   (u_in_word),
    .out_valid (u_out_valid),
    .out_ready (u_out_ready),
    .out_char  (u_out_char),
    .busy      (u_busy)
  );

  hex_word_serializer #(.NIBBLES(8), .UPPERCASE(0)) dut_lower (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (l_in_valid),
    .in_ready  (l_in_ready),
    .in_word   (l_in_word),
    .out_valid (l_out_valid),
    .out_ready (l_out_ready),
    .out_char  (l_out_char),
    .busy      (l_busy)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_in_valid = 1'b0; u_out_ready = 1'b0; u_in_word = 32'h0;
    l_in_valid = 1'b0; l_out_ready = 1'b0; l_in_word = 32'h0;
    repeat (3) tick();
    checks++;
    if (u_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hold_valid: got %b want 0", u_out_valid);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (u_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", u_in_ready);
    end
    checks++;
    if (u_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", u_out_valid);
    end
    checks++;
    if (u_out_char !== 8'h00) begin
      errors++; $display("FAIL reset_out_char: got %h want 00", u_out_char);
    end
    checks++;
    if (u_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", u_busy);
    end
    checks++;
    if (l_in_ready !== 1'b1 || l_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_lower: got ready=%b valid=%b want 1/0", l_in_ready, l_out_valid);
    end
  endtask

  task automatic test_uppercase_stream();
    string exp;
    exp = "1234ABCD";
    u_out_ready = 1'b1;
    u_in_word   = 32'h1234ABCD;
    u_in_valid  = 1'b1;
    tick();                       // accept edge
    u_in_valid = 1'b0;
    u_in_word  = 32'h0;           // must not affect the latched word
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (u_out_valid !== 1'b1 || u_out_char !== exp[i]) begin
        errors++;
        $display("FAIL upper_char[%0d]: got valid=%b char=%h want valid=1 char=%h", i, u_out_valid, u_out_char, exp[i]);
      end
      if (i == 0) begin
        checks++;
        if (u_in_ready !== 1'b0 || u_busy !== 1'b1) begin
          errors++; $display("FAIL upper_emit_flags: got ready=%b busy=%b want 0/1", u_in_ready, u_busy);
        end
      end
      tick();
    end
    checks++;
    if (u_in_ready !== 1'b1 || u_out_valid !== 1'b0 || u_busy !== 1'b0) begin
      errors++;
      $display("FAIL upper_idle_after: got ready=%b valid=%b busy=%b want 1/0/0", u_in_ready, u_out_valid, u_busy);
    end
  endtask

  task automatic test_lowercase_stall();
    string      exp;
    logic [7:0] got[$];
    logic       prev_stall;
    logic [7:0] prev_char;
    exp = "1234abcd";
    prev_stall  = 1'b0;
    prev_char   = 8'h00;
    l_out_ready = 1'b0;
    l_in_word   = 32'h1234ABCD;
    l_in_valid  = 1'b1;
    tick();
    l_in_valid = 1'b0;
    l_in_word  = 32'hFFFF_FFFF;
    for (int cyc = 0; cyc < 40 && got.size() < 8; cyc++) begin
      l_out_ready = (cyc % 2 == 1);
      if (prev_stall) begin
        checks++;
        if (l_out_valid !== 1'b1 || l_out_char !== prev_char) begin
          errors++;
          $display("FAIL lower_stall_hold: got valid=%b char=%h want valid=1 char=%h", l_out_valid, l_out_char, prev_char);
        end
      end
      if (l_out_valid && l_out_ready) got.push_back(l_out_char);
      prev_stall = l_out_valid && !l_out_ready;
      prev_char  = l_out_char;
      tick();
    end
    l_out_ready = 1'b0;
    checks++;
    if (got.size() != 8) begin
      errors++; $display("FAIL lower_count: got %0d want 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++; $display("FAIL lower_char[%0d]: got %h want %h", i, got[i], exp[i]);
        end
      end
    end
    checks++;
    if (l_in_ready !== 1'b1 || l_out_valid !== 1'b0) begin
      errors++; $display("FAIL lower_idle_after: got ready=%b valid=%b want 1/0", l_in_ready, l_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    string      exp;
    logic [7:0] got[$];
    int         n_acc;
    int         accept_at;
    int         overlaps;
    logic       just_acc;
    exp = "FFFFFFFF00000000";
    n_acc = 0; accept_at = -1; overlaps = 0; just_acc = 1'b0;
    u_out_ready = 1'b1;
    u_in_valid  = 1'b1;
    u_in_word   = 32'hFFFF_FFFF;
    for (int cyc = 0; cyc < 80 && got.size() < 16; cyc++) begin
      if (just_acc) begin
        just_acc = 1'b0;
        if (n_acc == 1) begin
          u_in_word = 32'h1357_9BDF;   // junk while rendering the first word
        end else begin
          u_in_valid = 1'b0;
          u_in_word  = 32'h2468_ACE0;  // junk while rendering the second word
        end
      end
      if (u_out_valid && u_out_ready) got.push_back(u_out_char);
      if (u_in_ready && u_out_valid) overlaps++;
      if (n_acc == 1 && u_in_ready) u_in_word = 32'h0000_0000;
      if (u_in_ready && u_in_valid) begin
        n_acc++;
        just_acc = 1'b1;
        if (n_acc == 2) accept_at = got.size();
      end
      tick();
    end
    u_in_valid = 1'b0;
    checks++;
    if (n_acc != 2) begin
      errors++; $display("FAIL b2b_accepts: got %0d want 2", n_acc);
    end
    checks++;
    if (accept_at != 8) begin
      errors++; $display("FAIL b2b_second_accept_after: got %0d chars want 8", accept_at);
    end
    checks++;
    if (overlaps != 0) begin
      errors++; $display("FAIL b2b_overlap: got %0d want 0", overlaps);
    end
    checks++;
    if (got.size() != 16) begin
      errors++; $display("FAIL b2b_count: got %0d want 16", got.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++; $display("FAIL b2b_char[%0d]: got %h want %h", i, got[i], exp[i]);
        end
      end
    end
    checks++;
    if (u_in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_idle_after: got %b want 1", u_in_ready);
    end
  endtask

  task automatic test_reset_mid_word();
    string exp;
    int    spurious;
    exp = "DEA";
    spurious = 0;
    u_out_ready = 1'b1;
    u_in_word   = 32'hDEAD_BEEF;
    u_in_valid  = 1'b1;
    tick();
    u_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (u_out_valid !== 1'b1 || u_out_char !== exp[i]) begin
        errors++;
        $display("FAIL midrst_char[%0d]: got valid=%b char=%h want valid=1 char=%h", i, u_out_valid, u_out_char, exp[i]);
      end
      tick();
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (u_out_valid !== 1'b0 || u_busy !== 1'b0 || u_out_char !== 8'h00) begin
      errors++;
      $display("FAIL midrst_state: got valid=%b busy=%b char=%h want 0/0/00", u_out_valid, u_busy, u_out_char);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (u_in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_in_ready: got %b want 1", u_in_ready);
    end
    repeat (12) begin
      if (u_out_valid) spurious++;
      tick();
    end
    checks++;
    if (spurious != 0) begin
      errors++; $display("FAIL midrst_spurious: got %0d chars want 0", spurious);
    end
  endtask

`ifdef HEX_SERIAL_CRLF_EN
  task automatic test_crlf();
    logic [7:0] exp[10];
    logic [7:0] got[$];
    int         stall_left;
    exp = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h41, 8'h0D, 8'h0A};
    stall_left  = 3;
    u_out_ready = 1'b1;
    u_in_word   = 32'h0000_000A;
    u_in_valid  = 1'b1;
    tick();
    u_in_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && got.size() < 10; cyc++) begin
      if (u_out_valid && u_out_char == 8'h0D && stall_left > 0) begin
        u_out_ready = 1'b0;
        if (stall_left < 3) begin
          checks++;
          if (u_out_valid !== 1'b1 || u_out_char !== 8'h0D) begin
            errors++; $display("FAIL crlf_cr_hold: got valid=%b char=%h want 1/0d", u_out_valid, u_out_char);
          end
        end
        stall_left--;
      end else begin
        u_out_ready = 1'b1;
      end
      if (u_out_valid && u_out_ready) got.push_back(u_out_char);
      tick();
    end
    checks++;
    if (got.size() != 10) begin
      errors++; $display("FAIL crlf_count: got %0d want 10", got.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++; $display("FAIL crlf_char[%0d]: got %h want %h", i, got[i], exp[i]);
        end
      end
    end
    checks++;
    if (u_in_ready !== 1'b1 || u_out_valid !== 1'b0) begin
      errors++; $display("FAIL crlf_idle_after: got ready=%b valid=%b want 1/0", u_in_ready, u_out_valid);
    end
  endtask
`else
  task automatic test_no_separator();
    logic [7:0] got[$];
    u_out_ready = 1'b1;
    u_in_word   = 32'h0000_000A;
    u_in_valid  = 1'b1;
    tick();
    u_in_valid = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (u_out_valid && u_out_ready) got.push_back(u_out_char);
      tick();
    end
    checks++;
    if (u_in_ready !== 1'b1 || u_out_valid !== 1'b0) begin
      errors++; $display("FAIL nosep_idle_after: got ready=%b valid=%b want 1/0", u_in_ready, u_out_valid);
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (u_out_valid && u_out_ready) got.push_back(u_out_char);
      tick();
    end
    checks++;
    if (got.size() != 8) begin
      errors++; $display("FAIL nosep_count: got %0d want 8", got.size());
    end else begin
      checks++;
      if (got[0] !== 8'h30 || got[6] !== 8'h30 || got[7] !== 8'h41) begin
        errors++; $display("FAIL nosep_chars: got %h..%h,%h want 30..30,41", got[0], got[6], got[7]);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_uppercase_stream();
    test_lowercase_stall();
    test_back_to_back();
    test_reset_mid_word();
`ifdef HEX_SERIAL_CRLF_EN
    test_crlf();
`else
    test_no_separator();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_hex_word_serializer
`default_nettype wire
